// File: rtl/reset_release_sequencer_if.sv
// Signal bundle between the reset release sequencer and the logic it serves:
// lock/request inputs and the sequenced reset and status outputs.
interface reset_release_sequencer_if #(
  parameter int NUM_OUT = 4
);
  logic               pll_lock;
  logic               sw_rst_req;
  logic [NUM_OUT-1:0] rst_out_n;
  logic               done;
  logic [2:0]         state_o;

  modport master (
    input  pll_lock,
    input  sw_rst_req,
    output rst_out_n,
    output done,
    output state_o
  );

  modport slave (
    output pll_lock,
    output sw_rst_req,
    input  rst_out_n,
    input  done,
    input  state_o
  );
endinterface

// File: rtl/reset_release_sequencer.sv
// Ordered reset generator: asynchronous assertion, synchronized and lock-filtered
// deassertion, one output domain released every STAGE_DELAY cycles.
module reset_release_sequencer #(
  parameter int NUM_OUT        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 4,
  parameter int STAGE_DELAY    = 8,
  parameter int SW_HOLD_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  reset_release_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_FILTER  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SW_HOLD = 3'd4
  } state_t;

  localparam int MAX_FS    = (FILTER_CYCLES > STAGE_DELAY) ? FILTER_CYCLES : STAGE_DELAY;
  localparam int MAX_DELAY = (MAX_FS > SW_HOLD_CYCLES) ? MAX_FS : SW_HOLD_CYCLES;
  localparam int IDX_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0]   FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]   SW_LAST     = CNT_W'(SW_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] BIT0_ONLY   = NUM_OUT'(1);

  // Parameter sanity: a counter that cannot hold the longest delay would wrap.
  generate
    if ((MAX_DELAY >> CNT_W) != 0) begin : g_cnt_w_too_small
      $error("reset_release_sequencer: CNT_W too small for the largest delay");
    end
    if (NUM_OUT < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 1 ||
        STAGE_DELAY < 1 || SW_HOLD_CYCLES < 1) begin : g_bad_param
      $error("reset_release_sequencer: parameter out of range");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] rst_chain_r;
  logic [SYNC_STAGES-1:0] lock_chain_r;
  logic                   rst_sync_s;
  logic                   lock_s;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       idx_r;
  logic [NUM_OUT-1:0]     rst_out_n_r;
  logic                   done_r;

  // Reset-release synchronizer: clears asynchronously, fills with ones on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      rst_chain_r <= {rst_chain_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // PLL lock synchronizer, also cleared by the master reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      lock_chain_r <= {lock_chain_r[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

  assign rst_sync_s = rst_chain_r[SYNC_STAGES-1];
  assign lock_s     = lock_chain_r[SYNC_STAGES-1];

  // Sequencer FSM with registered reset outputs; lock loss outranks sw requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HOLD;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      rst_out_n_r <= {NUM_OUT{1'b0}};
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          cnt_r       <= {CNT_W{1'b0}};
          idx_r       <= {IDX_W{1'b0}};
          rst_out_n_r <= {NUM_OUT{1'b0}};
          done_r      <= 1'b0;
          if (rst_sync_s && lock_s) begin
            state_r <= ST_FILTER;
          end else begin
            state_r <= ST_HOLD;
          end
        end

        ST_FILTER: begin
          if (!lock_s) begin
            state_r <= ST_HOLD;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == FILTER_LAST) begin
            cnt_r       <= {CNT_W{1'b0}};
            rst_out_n_r <= BIT0_ONLY;
            idx_r       <= IDX_W'(1);
            if (NUM_OUT == 1) begin
              state_r <= ST_RUN;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RELEASE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (!lock_s) begin
            state_r     <= ST_HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            rst_out_n_r <= {NUM_OUT{1'b0}};
            done_r      <= 1'b0;
          end else if (bus.sw_rst_req) begin
            state_r     <= ST_SW_HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            rst_out_n_r <= {NUM_OUT{1'b0}};
            done_r      <= 1'b0;
          end else if (cnt_r == STAGE_LAST) begin
            cnt_r              <= {CNT_W{1'b0}};
            rst_out_n_r[idx_r] <= 1'b1;
            if (idx_r == LAST_IDX) begin
              state_r <= ST_RUN;
              done_r  <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_r     <= ST_HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            rst_out_n_r <= {NUM_OUT{1'b0}};
            done_r      <= 1'b0;
          end else if (bus.sw_rst_req) begin
            state_r     <= ST_SW_HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            rst_out_n_r <= {NUM_OUT{1'b0}};
            done_r      <= 1'b0;
          end else begin
            rst_out_n_r <= {NUM_OUT{1'b1}};
            done_r      <= 1'b1;
          end
        end

        ST_SW_HOLD: begin
          if (!lock_s) begin
            state_r <= ST_HOLD;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == SW_LAST) begin
            cnt_r       <= {CNT_W{1'b0}};
            rst_out_n_r <= BIT0_ONLY;
            idx_r       <= IDX_W'(1);
            if (NUM_OUT == 1) begin
              state_r <= ST_RUN;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RELEASE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        default: begin
          state_r     <= ST_HOLD;
          cnt_r       <= {CNT_W{1'b0}};
          idx_r       <= {IDX_W{1'b0}};
          rst_out_n_r <= {NUM_OUT{1'b0}};
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_out_n = rst_out_n_r;
  assign bus.done      = done_r;
  assign bus.state_o   = state_r;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer with default parameters; edge numbers
// count clk rising edges after the point where rst_n is released.
module tb_reset_release_sequencer;

  logic clk;
  logic rst_n;
  int   edge_n;
  int   vectors;
  int   miscompares;

  reset_release_sequencer_if #(.NUM_OUT(4)) bus ();

  reset_release_sequencer #(
    .NUM_OUT(4), .SYNC_STAGES(2), .FILTER_CYCLES(4),
    .STAGE_DELAY(8), .SW_HOLD_CYCLES(16), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Bit i of the sequence is released on edge e0 + 8*i.
  function automatic logic [3:0] exp_bits(input int e, input int e0);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (e >= e0 + i * 8);
    return b;
  endfunction

  // Advance to edge 'last' checking outputs and done each edge against a sequence anchored at e0.
  task automatic run_seq(input int last, input int e0);
    while (edge_n < last) begin
      tick();
      check("rst_out_n", {28'd0, bus.rst_out_n}, {28'd0, exp_bits(edge_n, e0)});
      check("done", {31'd0, bus.done}, {31'd0, (edge_n >= e0 + 24)});
    end
  endtask

  // Hold rst_n low for two edges, then release it just after edge 0.
  task automatic power_up(input logic lock);
    rst_n        = 1'b0;
    bus.pll_lock = lock;
    tick();
    tick();
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    edge_n         = 0;
    rst_n          = 1'b0;
    bus.pll_lock   = 1'b1;
    bus.sw_rst_req = 1'b0;
    #2;
    check("reset_out", {28'd0, bus.rst_out_n}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_state", {29'd0, bus.state_o}, 32'd0);

    // Power-up with lock already high: 0001@7 0011@15 0111@23 1111@31.
    power_up(1'b1);
    run_seq(6, 7);
    check("filter_state", {29'd0, bus.state_o}, 32'd1);
    run_seq(7, 7);
    check("release_state", {29'd0, bus.state_o}, 32'd2);
    run_seq(35, 7);
    check("run_state", {29'd0, bus.state_o}, 32'd3);

    // Lock absent at release, raised after edge 20: first sampled on edge 21, bit0 at 27.
    power_up(1'b0);
    run_seq(20, 1000);
    check("nolock_hold", {29'd0, bus.state_o}, 32'd0);
    bus.pll_lock = 1'b1;
    run_seq(23, 27);
    check("late_lock_filter", {29'd0, bus.state_o}, 32'd1);
    run_seq(55, 27);
    check("late_lock_run", {29'd0, bus.state_o}, 32'd3);

    // One-cycle lock glitch during FILTER: back to HOLD, filter restarts, bit0 at 11.
    power_up(1'b1);
    run_seq(3, 11);
    check("glitch_pre_filter", {29'd0, bus.state_o}, 32'd1);
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    run_seq(6, 11);
    check("glitch_hold", {29'd0, bus.state_o}, 32'd0);
    run_seq(7, 11);
    check("glitch_refilter", {29'd0, bus.state_o}, 32'd1);
    run_seq(40, 11);

    // rst_n pulse between edges mid-RELEASE: outputs clear without a clock edge.
    power_up(1'b1);
    run_seq(16, 7);
    check("pre_pulse_bits", {28'd0, bus.rst_out_n}, 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out", {28'd0, bus.rst_out_n}, 32'd0);
    check("async_state", {29'd0, bus.state_o}, 32'd0);
    check("async_done", {31'd0, bus.done}, 32'd0);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    run_seq(99, 7);

    // Software re-reset sampled on edge 100; a second request in SW_HOLD is ignored.
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    check("sw_out", {28'd0, bus.rst_out_n}, 32'd0);
    check("sw_state", {29'd0, bus.state_o}, 32'd4);
    check("sw_done", {31'd0, bus.done}, 32'd0);
    run_seq(104, 116);
    bus.sw_rst_req = 1'b1;
    run_seq(105, 116);
    bus.sw_rst_req = 1'b0;
    check("sw_ignored_state", {29'd0, bus.state_o}, 32'd4);
    run_seq(115, 116);
    check("sw_hold_end", {29'd0, bus.state_o}, 32'd4);
    run_seq(116, 116);
    check("sw_release", {29'd0, bus.state_o}, 32'd2);
    run_seq(150, 116);
    check("sw_run", {29'd0, bus.state_o}, 32'd3);

    // Lock loss in RUN: lock_s low after edge 152, outputs clear on edge 153.
    bus.pll_lock = 1'b0;
    tick();
    tick();
    check("lockloss_still_run", {28'd0, bus.rst_out_n}, 32'hF);
    tick();
    check("lockloss_out", {28'd0, bus.rst_out_n}, 32'd0);
    check("lockloss_state", {29'd0, bus.state_o}, 32'd0);
    check("lockloss_done", {31'd0, bus.done}, 32'd0);
    run_seq(160, 1000);
    bus.pll_lock = 1'b1;
    run_seq(195, 167);
    check("relock_run", {29'd0, bus.state_o}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
